// File: rtl/c_mem_arbiter.sv
// Arbitrates the shared instruction/data memory between the fetch (I) and
// load/store (D) ports; one access in flight, accept -> issue -> respond.
module c_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter bit RR_EN  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req_valid,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_req_ready,
  output logic                i_rsp_valid,
  output logic [DATA_W-1:0]   i_rsp_rdata,
  input  logic                d_req_valid,
  input  logic                d_req_we,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_mask,
  output logic                d_req_ready,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_rdata,
  output logic                mem_request,
  output logic                mem_we_re,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_w_data,
  output logic [DATA_W/8-1:0] mem_masking,
  input  logic [DATA_W-1:0]   mem_r_data,
  output logic                busy
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state_reg, state_next;
  logic                owner_reg;       // 1 = D owns the transaction in flight
  logic                last_grant_reg;  // 1 = D was granted last
  logic [ADDR_W-1:0]   addr_reg;
  logic                we_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [MASK_W-1:0]   mask_reg;
  logic                grant_i, grant_d;

  always_comb begin
    state_next = state_reg;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_req_valid && d_req_valid) begin
          if (RR_EN) begin
            grant_i = last_grant_reg;
            grant_d = !last_grant_reg;
          end else begin
            grant_d = 1'b1;
          end
        end else begin
          grant_i = i_req_valid;
          grant_d = d_req_valid;
        end
        if (grant_i || grant_d) state_next = ISSUE;
      end
      ISSUE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The latched mask is already zeroed for fetches and loads, so it can be
  // driven straight onto the memory bus and still hold outside ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      mask_reg       <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_i || grant_d) begin
        owner_reg      <= grant_d;
        last_grant_reg <= grant_d;
        addr_reg       <= grant_d ? d_req_addr : i_req_addr;
        we_reg         <= grant_d && d_req_we;
        wdata_reg      <= grant_d ? d_req_wdata : '0;
        mask_reg       <= (grant_d && d_req_we) ? d_req_mask : '0;
      end
    end
  end

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  assign mem_request = (state_reg == ISSUE);
  assign mem_we_re   = (state_reg == ISSUE) && we_reg;
  assign mem_address = addr_reg;
  assign mem_w_data  = wdata_reg;
  assign mem_masking = mask_reg;

  assign i_rsp_valid = (state_reg == RESP) && !owner_reg;
  assign d_rsp_valid = (state_reg == RESP) && owner_reg;
  assign i_rsp_rdata = i_rsp_valid ? mem_r_data : '0;
  assign d_rsp_rdata = (d_rsp_valid && !we_reg) ? mem_r_data : '0;

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_c_mem_arbiter.sv
// Directed bench for c_mem_arbiter: a memory model behind the RR instance, a
// response scoreboard, and a second fixed-priority instance for arbitration.
module tb_c_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  // Round-robin instance
  logic        i_req_valid = 1'b0, i_req_ready, i_rsp_valid;
  logic [7:0]  i_req_addr = '0;
  logic [31:0] i_rsp_rdata;
  logic        d_req_valid = 1'b0, d_req_we = 1'b0, d_req_ready, d_rsp_valid;
  logic [7:0]  d_req_addr = '0;
  logic [31:0] d_req_wdata = '0, d_rsp_rdata;
  logic [3:0]  d_req_mask = '0;
  logic        mem_request, mem_we_re, busy;
  logic [7:0]  mem_address;
  logic [31:0] mem_w_data;
  logic [3:0]  mem_masking;
  logic [31:0] mem_r_data = '0;

  c_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_mask(d_req_mask), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
    .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_address(mem_address),
    .mem_w_data(mem_w_data), .mem_masking(mem_masking), .mem_r_data(mem_r_data),
    .busy(busy)
  );

  // Fixed-priority instance
  logic        p0_i_req_valid = 1'b0, p0_i_req_ready, p0_i_rsp_valid;
  logic [7:0]  p0_i_req_addr = 8'h55;
  logic [31:0] p0_i_rsp_rdata;
  logic        p0_d_req_valid = 1'b0, p0_d_req_ready, p0_d_rsp_valid;
  logic [7:0]  p0_d_req_addr = 8'h66;
  logic [31:0] p0_d_rsp_rdata;
  logic        p0_mem_request, p0_mem_we_re, p0_busy;
  logic [7:0]  p0_mem_address;
  logic [31:0] p0_mem_w_data;
  logic [3:0]  p0_mem_masking;
  logic [31:0] p0_mem_r_data = '0;

  c_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .RR_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(p0_i_req_valid), .i_req_addr(p0_i_req_addr), .i_req_ready(p0_i_req_ready),
    .i_rsp_valid(p0_i_rsp_valid), .i_rsp_rdata(p0_i_rsp_rdata),
    .d_req_valid(p0_d_req_valid), .d_req_we(1'b0), .d_req_addr(p0_d_req_addr),
    .d_req_wdata(32'h0), .d_req_mask(4'h0), .d_req_ready(p0_d_req_ready),
    .d_rsp_valid(p0_d_rsp_valid), .d_rsp_rdata(p0_d_rsp_rdata),
    .mem_request(p0_mem_request), .mem_we_re(p0_mem_we_re), .mem_address(p0_mem_address),
    .mem_w_data(p0_mem_w_data), .mem_masking(p0_mem_masking), .mem_r_data(p0_mem_r_data),
    .busy(p0_busy)
  );

  // Memory model (registered read, byte-masked write) and reference copy
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  always @(posedge clk) begin
    if (mem_request) begin
      if (mem_we_re) begin
        for (int b = 0; b < 4; b++)
          if (mem_masking[b]) mem[mem_address][8*b +: 8] <= mem_w_data[8*b +: 8];
      end else begin
        mem_r_data <= mem[mem_address];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic is_d, input logic [31:0] data);
    rsp_t e;
    e.is_d = is_d;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every response pulse must match the oldest expected entry
  always @(negedge clk) begin
    rsp_t e;
    if (i_rsp_valid || d_rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {30'b0, i_rsp_valid, d_rsp_valid}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_port", {30'b0, i_rsp_valid, d_rsp_valid}, e.is_d ? 32'h1 : 32'h2);
        check("rsp_data", e.is_d ? d_rsp_rdata : i_rsp_rdata, e.data);
      end
    end
  end

  // Called at negedge+1 in IDLE with valid raised; returns at ISSUE+1 with valid dropped.
  task automatic wait_accept(input bit is_d, input string tag);
    int n = 0;
    while (((is_d ? d_req_ready : i_req_ready) !== 1'b1) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_rdy"}, {31'b0, is_d ? d_req_ready : i_req_ready}, 32'h1);
    @(posedge clk); #1;
    if (is_d) d_req_valid = 1'b0;
    else i_req_valid = 1'b0;
  endtask

  task automatic do_d(input bit we, input logic [7:0] a, input logic [31:0] wd,
                      input logic [3:0] m, input logic [31:0] exp_rd, input string tag);
    d_req_valid = 1'b1; d_req_we = we; d_req_addr = a; d_req_wdata = wd; d_req_mask = m;
    push_exp(1'b1, we ? 32'h0 : exp_rd);
    if (we)
      for (int b = 0; b < 4; b++)
        if (m[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
    #1;
    wait_accept(1'b1, tag);
    check({tag, "_mreq"}, {31'b0, mem_request}, 32'h1);
    check({tag, "_we"}, {31'b0, mem_we_re}, {31'b0, we});
    check({tag, "_mask"}, {28'b0, mem_masking}, we ? {28'b0, m} : 32'h0);
    check({tag, "_addr"}, {24'b0, mem_address}, {24'b0, a});
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
  endtask

  // Both ports valid in IDLE (negedge+1); D is a load.
  task automatic contend_step(input bit exp_d, input bit drop, input string tag);
    push_exp(exp_d, exp_d ? ref_mem[d_req_addr] : ref_mem[i_req_addr]);
    check({tag, "_i_rdy"}, {31'b0, i_req_ready}, {31'b0, !exp_d});
    check({tag, "_d_rdy"}, {31'b0, d_req_ready}, {31'b0, exp_d});
    @(posedge clk); #1;
    check({tag, "_addr"}, {24'b0, mem_address}, exp_d ? {24'b0, d_req_addr} : {24'b0, i_req_addr});
    if (drop) begin
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 32'hC0DE0000 | a;
    mem[8'h10] = 32'h00500093;
    mem[8'h20] = 32'h11223344;
    for (int a = 0; a < 256; a++) ref_mem[a] = mem[a];

    // Reset state
    #2;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_mreq", {31'b0, mem_request}, 32'h0);
    check("rst_we", {31'b0, mem_we_re}, 32'h0);
    check("rst_addr", {24'b0, mem_address}, 32'h0);
    check("rst_wdata", mem_w_data, 32'h0);
    check("rst_mask", {28'b0, mem_masking}, 32'h0);
    check("rst_rsp", {30'b0, i_rsp_valid, d_rsp_valid}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // Contention from reset, round-robin: I, D, I, D
    i_req_valid = 1'b1; i_req_addr = 8'h30;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 8'h31;
    #1;
    contend_step(1'b0, 1'b0, "rr0");
    contend_step(1'b1, 1'b0, "rr1");
    contend_step(1'b0, 1'b0, "rr2");
    contend_step(1'b1, 1'b1, "rr3");

    // Single fetch, cycle-exact
    i_req_valid = 1'b1; i_req_addr = 8'h10;
    push_exp(1'b0, 32'h00500093);
    #1;
    check("f_rdy_c0", {31'b0, i_req_ready}, 32'h1);
    check("f_busy_c0", {31'b0, busy}, 32'h0);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    check("f_mreq_c1", {31'b0, mem_request}, 32'h1);
    check("f_addr_c1", {24'b0, mem_address}, 32'h10);
    check("f_we_c1", {31'b0, mem_we_re}, 32'h0);
    check("f_mask_c1", {28'b0, mem_masking}, 32'h0);
    check("f_busy_c1", {31'b0, busy}, 32'h1);
    @(posedge clk); #1;
    check("f_mreq_c2", {31'b0, mem_request}, 32'h0);
    check("f_rsp_c2", {31'b0, i_rsp_valid}, 32'h1);
    check("f_data_c2", i_rsp_rdata, 32'h00500093);
    @(posedge clk);
    @(negedge clk); #1;
    check("f_busy_c3", {31'b0, busy}, 32'h0);

    // Masked store then load
    do_d(1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, 32'h0, "st");
    do_d(1'b0, 8'h20, 32'h0, 4'b1111, 32'h11BB33DD, "ld");

    // D request raised during ISSUE of a fetch
    i_req_valid = 1'b1; i_req_addr = 8'h44;
    push_exp(1'b0, ref_mem[8'h44]);
    #1;
    wait_accept(1'b0, "w_i");
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 8'h20;
    push_exp(1'b1, 32'h11BB33DD);
    #1;
    check("w_drdy_issue", {31'b0, d_req_ready}, 32'h0);
    check("w_mreq_issue", {31'b0, mem_request}, 32'h1);
    @(posedge clk); #1;
    check("w_drdy_resp", {31'b0, d_req_ready}, 32'h0);
    check("w_mreq_resp", {31'b0, mem_request}, 32'h0);
    @(posedge clk); #1;
    check("w_drdy_idle", {31'b0, d_req_ready}, 32'h1);
    check("w_mreq_idle", {31'b0, mem_request}, 32'h0);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    check("w_mreq_d", {31'b0, mem_request}, 32'h1);
    check("w_addr_d", {24'b0, mem_address}, 32'h20);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;

    // Reset during ISSUE abandons the fetch
    i_req_valid = 1'b1; i_req_addr = 8'h40;
    #1;
    wait_accept(1'b0, "r_i");
    check("r_mreq_issue", {31'b0, mem_request}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("r_mreq_rst", {31'b0, mem_request}, 32'h0);
    check("r_busy_rst", {31'b0, busy}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("r_busy_after", {31'b0, busy}, 32'h0);
    i_req_valid = 1'b1; i_req_addr = 8'h10;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 8'h20;
    #1;
    contend_step(1'b0, 1'b0, "r_tie0");
    contend_step(1'b1, 1'b1, "r_tie1");

    // Fixed priority: D wins while held, I served once D drops
    p0_i_req_valid = 1'b1;
    p0_d_req_valid = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("fp_d_rdy", {31'b0, p0_d_req_ready}, 32'h1);
      check("fp_i_rdy", {31'b0, p0_i_req_ready}, 32'h0);
      @(posedge clk); #1;
      if (k == 2) p0_d_req_valid = 1'b0;
      @(posedge clk); #1;
      check("fp_d_rsp", {30'b0, p0_i_rsp_valid, p0_d_rsp_valid}, 32'h1);
      @(posedge clk);
      @(negedge clk); #1;
    end
    check("fp_i_rdy_last", {31'b0, p0_i_req_ready}, 32'h1);
    check("fp_d_rdy_last", {31'b0, p0_d_req_ready}, 32'h0);
    @(posedge clk); #1;
    p0_i_req_valid = 1'b0;
    check("fp_i_addr", {24'b0, p0_mem_address}, 32'h55);
    check("fp_busy", {31'b0, p0_busy}, 32'h1);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;

    check("sb_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
